// File: rtl/ext_trigger_out_generator.sv
// ext_trigger_out_generator: turns a one-cycle trigger request into a timed external trigger pulse
// Ports:
//   clk_i, rst_n_i            clock and synchronous active-low reset
//   micro_ce_i                1 us time-base strobe; all widths count these ticks
//   enable_i                  gates acceptance of new requests only
//   trig_req_i                one-cycle trigger request
//   width_i, holdoff_i        pulse width (0 acts as 1) and post-pulse holdoff in ticks
//   trig_o                    registered trigger drive, idle level = INVERT
//   busy_o                    high while a pulse or holdoff is in progress
//   accepted_o, dropped_o     one-cycle strobes for started / discarded requests
//   drop_count_o              saturating count of discarded requests
//   pulse_count_o             wrapping count of issued pulses
module ext_trigger_out_generator #(
    parameter bit          INVERT = 1'b0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             micro_ce_i,
    input  logic             enable_i,
    input  logic             trig_req_i,
    input  logic [7:0]       width_i,
    input  logic [7:0]       holdoff_i,
    output logic             trig_o,
    output logic             busy_o,
    output logic             accepted_o,
    output logic             dropped_o,
    output logic [7:0]       drop_count_o,
    output logic [CNT_W-1:0] pulse_count_o
);
    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic [7:0] hold_q;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            hold_q        <= 8'd0;
            trig_o        <= INVERT;
            busy_o        <= 1'b0;
            accepted_o    <= 1'b0;
            dropped_o     <= 1'b0;
            drop_count_o  <= 8'd0;
            pulse_count_o <= '0;
        end else begin
            accepted_o <= 1'b0;
            dropped_o  <= 1'b0;
            // any non-IDLE state rejects, including the edge that returns to IDLE
            if (trig_req_i && enable_i && state != IDLE) begin
                dropped_o <= 1'b1;
                if (drop_count_o != 8'hff)
                    drop_count_o <= drop_count_o + 8'd1;
            end
            case (state)
                IDLE: begin
                    // a tick coincident with acceptance is ignored: nothing counts in IDLE
                    if (trig_req_i && enable_i) begin
                        state         <= PULSE;
                        trig_o        <= !INVERT;
                        busy_o        <= 1'b1;
                        accepted_o    <= 1'b1;
                        pulse_count_o <= pulse_count_o + CNT_W'(1);
                        cnt           <= (width_i == 8'd0) ? 8'd1 : width_i;
                        hold_q        <= holdoff_i;
                    end
                end
                PULSE: begin
                    if (micro_ce_i) begin
                        if (cnt == 8'd1) begin
                            trig_o <= INVERT;
                            if (hold_q == 8'd0) begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end else begin
                                state <= HOLDOFF;
                                cnt   <= hold_q;
                            end
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (micro_ce_i) begin
                        if (cnt == 8'd1) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    trig_o <= INVERT;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ext_trigger_out_generator.sv
// tb_ext_trigger_out_generator: scoreboard bench for both trigger polarities
module tb_ext_trigger_out_generator;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        micro_ce_i = 1'b0;
    logic        enable_i = 1'b1;
    logic        trig_req_i = 1'b0;
    logic [7:0]  width_i = 8'd0;
    logic [7:0]  holdoff_i = 8'd0;
    logic        trig_o, busy_o, accepted_o, dropped_o;
    logic [7:0]  drop_count_o;
    logic [15:0] pulse_count_o;
    logic        inv_trig, inv_busy, inv_acc, inv_drop;
    logic [7:0]  inv_dc;
    logic [15:0] inv_pc;

    ext_trigger_out_generator #(.INVERT(1'b0), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .micro_ce_i(micro_ce_i), .enable_i(enable_i),
        .trig_req_i(trig_req_i), .width_i(width_i), .holdoff_i(holdoff_i),
        .trig_o(trig_o), .busy_o(busy_o), .accepted_o(accepted_o), .dropped_o(dropped_o),
        .drop_count_o(drop_count_o), .pulse_count_o(pulse_count_o)
    );

    ext_trigger_out_generator #(.INVERT(1'b1), .CNT_W(16)) dut_inv (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .micro_ce_i(micro_ce_i), .enable_i(enable_i),
        .trig_req_i(trig_req_i), .width_i(width_i), .holdoff_i(holdoff_i),
        .trig_o(inv_trig), .busy_o(inv_busy), .accepted_o(inv_acc), .dropped_o(inv_drop),
        .drop_count_o(inv_dc), .pulse_count_o(inv_pc)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {bit drop; int pc; int dc; int w; bit busy_after;} ev_t;
    typedef struct {bit trig; bit busy; int pc; int dc;} st_t;
    ev_t ev_q[$];
    st_t st_q[$];

    int  checks = 0;
    int  errors = 0;
    bit  done = 1'b0;
    int  pc = 0;
    int  dc = 0;
    int  ph = 0;
    int  ce_per = 10;
    bit  ce_run = 1'b0;
    bit  meas_on = 1'b0;
    int  meas = 0;
    int  exp_w = 0;
    bit  exp_b = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit req);
        trig_req_i = req;
        micro_ce_i = ce_run && (ph == ce_per - 1);
        ph = (ph == ce_per - 1) ? 0 : ph + 1;
        @(posedge clk_i);
        #1;
        trig_req_i = 1'b0;
        micro_ce_i = 1'b0;
    endtask

    task automatic expect_acc(input int w, input bit busy_after);
        ev_t e;
        pc++;
        e.drop = 1'b0; e.pc = pc; e.dc = dc; e.w = w; e.busy_after = busy_after;
        ev_q.push_back(e);
    endtask

    task automatic expect_drop();
        ev_t e;
        dc = (dc < 255) ? dc + 1 : 255;
        e.drop = 1'b1; e.pc = pc; e.dc = dc; e.w = 0; e.busy_after = 1'b0;
        ev_q.push_back(e);
    endtask

    task automatic snap(input bit trig, input bit busy);
        st_t s;
        s.trig = trig; s.busy = busy; s.pc = pc; s.dc = dc;
        st_q.push_back(s);
    endtask

    // monitor: every strobe pops the next expected event; pulse widths are measured here
    initial begin
        st_t s;
        ev_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                meas_on = 1'b0;
            end else begin
                while (st_q.size() > 0) begin
                    s = st_q.pop_front();
                    chk("idle_trig", trig_o, s.trig);
                    chk("inv_trig", inv_trig, !s.trig);
                    chk("busy", busy_o, s.busy);
                    chk("inv_busy", inv_busy, s.busy);
                    chk("pulse_count", pulse_count_o, s.pc);
                    chk("inv_pulse_count", inv_pc, s.pc);
                    chk("drop_count", drop_count_o, s.dc);
                    chk("inv_drop_count", inv_dc, s.dc);
                end
                if (accepted_o || dropped_o) begin
                    if (ev_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe accepted=%0b dropped=%0b required none at %0t",
                                 accepted_o, dropped_o, $time);
                    end else begin
                        e = ev_q.pop_front();
                        chk("strobe_dropped", dropped_o, e.drop);
                        chk("strobe_accepted", accepted_o, !e.drop);
                        chk("inv_strobe_dropped", inv_drop, e.drop);
                        chk("inv_strobe_accepted", inv_acc, !e.drop);
                        chk("ev_pulse_count", pulse_count_o, e.pc);
                        chk("ev_drop_count", drop_count_o, e.dc);
                        if (!e.drop) begin
                            chk("trig_on_accept", trig_o, 1);
                            chk("inv_trig_on_accept", inv_trig, 0);
                            chk("busy_on_accept", busy_o, 1);
                            meas_on = 1'b1;
                            meas = 0;
                            exp_w = e.w;
                            exp_b = e.busy_after;
                        end
                    end
                end
                if (meas_on) begin
                    if (trig_o) begin
                        meas++;
                    end else begin
                        meas_on = 1'b0;
                        chk("pulse_width_clks", meas, exp_w);
                        chk("busy_after_pulse", busy_o, exp_b);
                        chk("inv_trig_after_pulse", inv_trig, 1);
                    end
                end
            end
            if (done) begin
                chk("leftover_events", ev_q.size(), 0);
                chk("leftover_snapshots", st_q.size(), 0);
                chk("pulse_unfinished", meas_on, 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc(1'b0);
        rst_n_i = 1'b1;
        snap(1'b0, 1'b0);
        cyc(1'b0);
        // width 3, no holdoff, tick every 10 clocks aligned so ticks hit 9/19/29 clocks later
        width_i = 8'd3; holdoff_i = 8'd0; ce_run = 1'b1; ce_per = 10; ph = 0;
        expect_acc(29, 1'b0);
        cyc(1'b1);
        repeat (40) cyc(1'b0);
        snap(1'b0, 1'b0);
        // width 0 and width 1 both last one tick
        width_i = 8'd0; ph = 0;
        expect_acc(9, 1'b0);
        cyc(1'b1);
        repeat (15) cyc(1'b0);
        // tick coincident with acceptance is not counted: next tick 10 clocks later
        width_i = 8'd1; ph = 9;
        expect_acc(10, 1'b0);
        cyc(1'b1);
        repeat (15) cyc(1'b0);
        snap(1'b0, 1'b0);
        // disabled requests are ignored entirely
        enable_i = 1'b0;
        repeat (5) cyc(1'b1);
        snap(1'b0, 1'b0);
        cyc(1'b0);
        // enable dropped mid-pulse: full width, disabled request not counted
        enable_i = 1'b1; width_i = 8'd3; ph = 0;
        expect_acc(29, 1'b0);
        cyc(1'b1);
        enable_i = 1'b0;
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        repeat (36) cyc(1'b0);
        enable_i = 1'b1;
        snap(1'b0, 1'b0);
        cyc(1'b0);
        // tick every clock, width 2 holdoff 4: accept, drop, drop (last drop lands on return-to-IDLE edge)
        width_i = 8'd2; holdoff_i = 8'd4; ce_per = 1; ph = 0;
        for (int i = 0; i < 34; i++) begin
            if (i % 3 == 0) expect_acc(2, 1'b1);
            else expect_drop();
            cyc(1'b1);
            cyc(1'b0);
            cyc(1'b0);
        end
        repeat (10) cyc(1'b0);
        snap(1'b0, 1'b0);
        cyc(1'b0);
        // ticks stopped so the pulse holds while 300 requests are dropped; count saturates
        width_i = 8'd1; holdoff_i = 8'd0; ce_run = 1'b0;
        expect_acc(301, 1'b0);
        cyc(1'b1);
        for (int i = 0; i < 300; i++) begin
            expect_drop();
            cyc(1'b1);
        end
        ce_run = 1'b1; ce_per = 1; ph = 0;
        cyc(1'b0);
        repeat (3) cyc(1'b0);
        snap(1'b0, 1'b0);
        cyc(1'b0);
        // reset in the middle of a pulse
        width_i = 8'd3; ce_per = 10; ph = 0;
        expect_acc(29, 1'b0);
        cyc(1'b1);
        repeat (5) cyc(1'b0);
        snap(1'b1, 1'b1);
        cyc(1'b0);
        rst_n_i = 1'b0;
        cyc(1'b0);
        rst_n_i = 1'b1;
        pc = 0;
        dc = 0;
        snap(1'b0, 1'b0);
        cyc(1'b0);
        ph = 0;
        expect_acc(29, 1'b0);
        cyc(1'b1);
        repeat (35) cyc(1'b0);
        snap(1'b0, 1'b0);
        cyc(1'b0);
        done = 1'b1;
        repeat (10) @(posedge clk_i);
        $display("FAIL monitor did not finish");
        $fatal(1, "monitor stalled");
    end
endmodule

// File: doc/ext_trigger_out_generator.md
Name: ext_trigger_out_generator

Overview:
Drives the station's external trigger output: converts a single-cycle internal trigger request into a registered pulse on the external trigger pin. Pulse width and post-pulse holdoff are programmable in micro_ce_i ticks. This is the transmit counterpart of the external trigger input flag/holdoff path. Requests arriving while a pulse or holdoff is in progress are dropped and counted, never queued.

Parameters:
INVERT, 0, 1 = trig_o idles high and pulses low; 0 = idles low, pulses high
CNT_W, 16, width of issued-pulse counter

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  synchronous reset, active low
micro_ce_i  input  1  one-cycle time-base strobe (1 µs tick)
enable_i  input  1  1 = requests accepted; 0 = requests ignored (not counted as dropped)
trig_req_i  input  1  one-cycle trigger request
width_i  input  8  pulse width in ticks; 0 treated as 1
holdoff_i  input  8  holdoff after pulse in ticks; 0 = none
trig_o  output  1  registered external trigger drive
busy_o  output  1  1 when state != IDLE
accepted_o  output  1  one-cycle strobe: request started a pulse
dropped_o  output  1  one-cycle strobe: request discarded while busy
drop_count_o  output  8  dropped requests, saturates at 255
pulse_count_o  output  CNT_W  pulses issued, wraps at 2^CNT_W

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): state IDLE, tick counter 0, trig_o = INVERT, busy_o/accepted_o/dropped_o = 0, both counts = 0. Reset mid-pulse returns trig_o to idle level on the next edge; no partial completion.
- All outputs registered. trig_o active level = !INVERT.
- FSM states: IDLE, PULSE, HOLDOFF.
- IDLE: trig_req_i && enable_i at edge N -> from N+1: trig_o active, accepted_o=1 for one cycle, pulse_count_o+1, cnt <= max(width_i,1), state PULSE. width_i/holdoff_i sampled only here; holdoff latched into a shadow register.
- PULSE: on each micro_ce_i, cnt decrements. When micro_ce_i && cnt==1: trig_o returns to idle at the next edge. Then if latched holdoff==0 -> IDLE; else cnt <= holdoff and state HOLDOFF.
- HOLDOFF: trig_o idle. On micro_ce_i, cnt decrements. When micro_ce_i && cnt==1 -> IDLE.
- Pulse duration: between (W-1) and W tick periods plus one clock (W = effective width), since the first tick may arrive immediately. Holdoff has the same quantisation.
- trig_req_i in PULSE or HOLDOFF (enable_i=1): dropped_o=1 next cycle; drop_count_o increments, saturating at 255. No effect on timing.
- Request arriving on the same edge that state transitions to IDLE: treated as busy and dropped. IDLE is entered on the following edge.
- enable_i low in PULSE/HOLDOFF: sequence completes unchanged. enable_i only gates new acceptance.
- micro_ce_i coincident with request acceptance: not counted against the new pulse.
- busy_o = (state != IDLE), registered with the state.

Test Plan:
- Reset then idle, INVERT=0: trig_o=0, busy_o=0, counts 0. Repeat with INVERT=1 -> trig_o=1.
- width_i=3, holdoff_i=0, micro_ce every 10 clks, request at edge N: trig_o high from N+1, low after the 3rd subsequent tick edge +1; accepted_o one cycle; pulse_count_o=1; busy_o drops the same cycle trig_o falls.
- width_i=0: behaves exactly as width_i=1 (one tick).
- width_i=2, holdoff_i=4, requests every 3 clocks for 100 clocks: exactly one pulse per (2+4)-tick window; dropped_o asserted for each rejected request; drop_count_o equals the rejected count; saturates at 255 under 300 drops.
- enable_i=0 with requests: no pulse, no accepted_o, no drop count. enable_i deasserted mid-pulse: pulse still completes full width.
- Reset asserted during PULSE: trig_o idle on the next edge, counts cleared; a request after reset starts a fresh pulse normally.
